// File: rtl/bram_dp_responder_pkg.sv
// bram_dp_responder_pkg: shared types for the BRAM responder slice.
// Controller state encoding and a small occupancy helper.
package bram_dp_responder_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_DUMP = 2'd2
   } state_e;

   function automatic logic [1:0] occ3(
      input logic a,
      input logic b,
      input logic c
   );
      return {1'b0, a} + {1'b0, b} + {1'b0, c};
   endfunction

endpackage

// File: rtl/bram_dp_responder_array.sv
// bram_dp_responder_array: DEPTH x DATA_WIDTH two-port storage.
// Ports: clk; per port reN_i/weN_i/addrN_i/wdataN_i in, rdataN_o out.
// Reads are synchronous read-first; port 1 wins a same-address write.
module bram_dp_responder_array #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  re0_i,
   input  logic                  we0_i,
   input  logic [ADDR_WIDTH-1:0] addr0_i,
   input  logic [DATA_WIDTH-1:0] wdata0_i,
   output logic [DATA_WIDTH-1:0] rdata0_o,
   input  logic                  re1_i,
   input  logic                  we1_i,
   input  logic [ADDR_WIDTH-1:0] addr1_i,
   input  logic [DATA_WIDTH-1:0] wdata1_i,
   output logic [DATA_WIDTH-1:0] rdata1_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd0_q;
   logic [DATA_WIDTH-1:0] rd1_q;

   // later assignment wins: port 1 has write priority
   always_ff @(posedge clk) begin
      if (we0_i) mem_q[addr0_i] <= wdata0_i;
      if (we1_i) mem_q[addr1_i] <= wdata1_i;
   end

   always_ff @(posedge clk) begin
      if (re0_i) rd0_q <= mem_q[addr0_i];
      if (re1_i) rd1_q <= mem_q[addr1_i];
   end

   assign rdata0_o = rd0_q;
   assign rdata1_o = rd1_q;

endmodule

// File: rtl/bram_dp_responder.sv
// bram_dp_responder: memory side of a BRAM port pair with preload/dump.
// Ports: clk, rst (async, active-low); kernel ports ce/we/address/dout
// -> din (1-cycle); init_* preload stream in; dump_* readback stream
// out; run_active, err_sticky status.
module bram_dp_responder
   import bram_dp_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] address0,
   input  logic [DATA_WIDTH-1:0] dout0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic                  ce1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] address1,
   input  logic [DATA_WIDTH-1:0] dout1,
   output logic [DATA_WIDTH-1:0] din1,
   input  logic                  init_valid,
   output logic                  init_ready,
   input  logic [DATA_WIDTH-1:0] init_data,
   input  logic                  init_last,
   input  logic                  dump_req,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  dump_last,
   output logic                  run_active,
   output logic                  err_sticky
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C =
      (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST_R =
      (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_A =
      ADDR_WIDTH'(DEPTH - 1);

   state_e state_q, state_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d;

   logic run, in_init, in_dump;
   logic init_fire, init_done;
   logic dump_go, dump_pop, dump_done, issue;
   logic inr0, inr1;
   logic p0_rd, p0_wr, p0_oor_rd;
   logic p1_rd, p1_wr, p1_oor_rd;
   logic bad_acc;
   logic [1:0] occ;

   logic                  live0_q, live1_q;
   logic [DATA_WIDTH-1:0] hold0_q, hold1_q;
   logic                  err_q;

   logic                  pend_q, pend_last_q;
   logic                  out_v_q, out_last_q;
   logic [DATA_WIDTH-1:0] out_q;
   logic                  sk_v_q, sk_last_q;
   logic [DATA_WIDTH-1:0] sk_q;

   logic                  a_re0, a_we0, a_re1, a_we1;
   logic [ADDR_WIDTH-1:0] a_addr0, a_addr1;
   logic [DATA_WIDTH-1:0] a_wdata0, a_wdata1;
   logic [DATA_WIDTH-1:0] a_rd0, a_rd1;

   assign run     = (state_q == ST_RUN);
   assign in_init = (state_q == ST_INIT);
   assign in_dump = (state_q == ST_DUMP);

   assign init_fire = init_valid && in_init;
   assign init_done = init_fire
                   && (init_last || wptr_q == LAST_A);

   assign dump_go = run && dump_req && !ce0 && !ce1;

   assign inr0 = {1'b0, address0} < DEPTH_C;
   assign inr1 = {1'b0, address1} < DEPTH_C;

   assign p0_rd     = run && ce0 && !we0 && inr0;
   assign p0_wr     = run && ce0 && we0 && inr0;
   assign p0_oor_rd = run && ce0 && !we0 && !inr0;
   assign p1_rd     = run && ce1 && !we1 && inr1;
   assign p1_wr     = run && ce1 && we1 && inr1;
   assign p1_oor_rd = run && ce1 && !we1 && !inr1;

   assign bad_acc = (!run && (ce0 || ce1))
                 || (run && ce0 && !inr0)
                 || (run && ce1 && !inr1);

   // dump slots: output reg + skid; in-flight read counts as taken
   assign occ       = occ3(out_v_q, sk_v_q, pend_q);
   assign dump_pop  = out_v_q && dump_ready;
   assign dump_done = dump_pop && out_last_q;
   assign issue     = in_dump && (rptr_q < DEPTH_C)
                   && ((occ < 2'd2) || dump_pop);

   // array port 0: kernel load port or dump reader
   assign a_re0    = p0_rd || issue;
   assign a_we0    = p0_wr;
   assign a_addr0  = in_dump ? rptr_q[ADDR_WIDTH-1:0] : address0;
   assign a_wdata0 = dout0;

   // array port 1: kernel store port or preload writer
   assign a_re1    = p1_rd;
   assign a_we1    = p1_wr || init_fire;
   assign a_addr1  = in_init ? wptr_q : address1;
   assign a_wdata1 = in_init ? init_data : dout1;

   bram_dp_responder_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk      (clk),
      .re0_i    (a_re0),
      .we0_i    (a_we0),
      .addr0_i  (a_addr0),
      .wdata0_i (a_wdata0),
      .rdata0_o (a_rd0),
      .re1_i    (a_re1),
      .we1_i    (a_we1),
      .addr1_i  (a_addr1),
      .wdata1_i (a_wdata1),
      .rdata1_o (a_rd1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_INIT;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT: if (init_done) state_d = ST_RUN;
         ST_RUN:  if (dump_go)   state_d = ST_DUMP;
         ST_DUMP: if (dump_done) state_d = ST_INIT;
         default: state_d = ST_INIT;
      endcase
   end

   always_comb begin
      run_active = 1'b0;
      init_ready = 1'b0;
      unique case (1'b1)
         in_init: init_ready = 1'b1;
         run:     run_active = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (init_fire)
         wptr_d = init_done ? '0 : wptr_q + 1'b1;
      if (dump_done)
         wptr_d = '0;
      if (dump_go)
         rptr_d = '0;
      else if (issue)
         rptr_d = rptr_q + 1'b1;
   end

   // din shows the fresh array word right after a read,
   // otherwise the captured copy, so dump reads never leak out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live0_q <= 1'b0;
         live1_q <= 1'b0;
         hold0_q <= '0;
         hold1_q <= '0;
         err_q   <= 1'b0;
      end else begin
         live0_q <= p0_rd;
         live1_q <= p1_rd;
         if (live0_q)   hold0_q <= a_rd0;
         if (p0_oor_rd) hold0_q <= '0;
         if (live1_q)   hold1_q <= a_rd1;
         if (p1_oor_rd) hold1_q <= '0;
         if (bad_acc)   err_q   <= 1'b1;
      end
   end

   assign din0       = live0_q ? a_rd0 : hold0_q;
   assign din1       = live1_q ? a_rd1 : hold1_q;
   assign err_sticky = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         out_v_q     <= 1'b0;
         out_last_q  <= 1'b0;
         out_q       <= '0;
         sk_v_q      <= 1'b0;
         sk_last_q   <= 1'b0;
         sk_q        <= '0;
      end else begin
         pend_q      <= issue;
         pend_last_q <= issue && (rptr_q == LAST_R);
         if (!out_v_q || dump_pop) begin
            if (sk_v_q) begin
               out_v_q    <= 1'b1;
               out_q      <= sk_q;
               out_last_q <= sk_last_q;
               sk_v_q     <= pend_q;
               sk_q       <= a_rd0;
               sk_last_q  <= pend_last_q;
            end else begin
               out_v_q    <= pend_q;
               out_last_q <= pend_last_q;
               if (pend_q) out_q <= a_rd0;
            end
         end else if (pend_q) begin
            sk_v_q    <= 1'b1;
            sk_q      <= a_rd0;
            sk_last_q <= pend_last_q;
         end
      end
   end

   assign dump_valid = out_v_q;
   assign dump_data  = out_q;
   assign dump_last  = out_v_q && out_last_q;

endmodule

// File: tb/tb_bram_dp_responder.sv
// tb_bram_dp_responder: random + directed bench for bram_dp_responder.
// Behavioural array/status model; dump stream checked word by word.
module tb_bram_dp_responder;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ce0 = 1'b0, we0 = 1'b0;
   logic          ce1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] address0 = '0, address1 = '0;
   logic [DW-1:0] dout0 = '0, dout1 = '0;
   logic [DW-1:0] din0, din1;
   logic          init_valid = 1'b0, init_last = 1'b0;
   logic [DW-1:0] init_data = '0;
   logic          init_ready;
   logic          dump_req = 1'b0, dump_ready = 1'b0;
   logic          dump_valid, dump_last;
   logic [DW-1:0] dump_data;
   logic          run_active, err_sticky;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] din0_m = '0, din1_m = '0;
   bit            err_m  = 1'b0;
   int            mode_m = 0;
   int            wptr_m = 0;

   always #5 clk = ~clk;

   bram_dp_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce0        (ce0),
      .we0        (we0),
      .address0   (address0),
      .dout0      (dout0),
      .din0       (din0),
      .ce1        (ce1),
      .we1        (we1),
      .address1   (address1),
      .dout1      (dout1),
      .din1       (din1),
      .init_valid (init_valid),
      .init_ready (init_ready),
      .init_data  (init_data),
      .init_last  (init_last),
      .dump_req   (dump_req),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_data  (dump_data),
      .dump_last  (dump_last),
      .run_active (run_active),
      .err_sticky (err_sticky)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // model of one clock edge with the currently driven inputs
   task automatic step();
      if (mode_m == 1) begin
         if (ce0) begin
            if (int'(address0) >= DEPTH) begin
               err_m = 1'b1;
               if (!we0) din0_m = '0;
            end else if (!we0) din0_m = mem_m[address0];
         end
         if (ce1) begin
            if (int'(address1) >= DEPTH) begin
               err_m = 1'b1;
               if (!we1) din1_m = '0;
            end else if (!we1) din1_m = mem_m[address1];
         end
         if (ce0 && we0 && int'(address0) < DEPTH)
            mem_m[address0] = dout0;
         if (ce1 && we1 && int'(address1) < DEPTH)
            mem_m[address1] = dout1;
         if (dump_req && !ce0 && !ce1) mode_m = 2;
      end else begin
         if (ce0 || ce1) err_m = 1'b1;
         if (mode_m == 0 && init_valid) begin
            mem_m[wptr_m] = init_data;
            if (init_last || wptr_m == DEPTH - 1) begin
               mode_m = 1;
               wptr_m = 0;
            end else wptr_m++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag);
      check({tag, ".run"},  run_active, mode_m == 1);
      check({tag, ".rdy"},  init_ready, mode_m == 0);
      check({tag, ".err"},  err_sticky, err_m);
      check({tag, ".din0"}, din0, din0_m);
      check({tag, ".din1"}, din1, din1_m);
   endtask

   task automatic run_dump(input bit rnd, input string tag);
      int idx, cyc;
      bit done, pv, pr;
      logic [DW-1:0] pd;
      idx = 0; cyc = 0; done = 0;
      pv = 0; pr = 0; pd = '0;
      dump_req = 1'b1;
      step();
      dump_req = 1'b0;
      check({tag, ".enter"}, run_active, 1'b0);
      while (!done && cyc < 20 * DEPTH) begin
         if (pv && !pr) begin
            check({tag, ".stall_v"}, dump_valid, 1'b1);
            check({tag, ".stall_d"}, dump_data, pd);
         end
         dump_ready = rnd ? 1'($urandom_range(0, 1))
                          : 1'(cyc % 2 == 0);
         if (dump_valid && dump_ready) begin
            check({tag, ".data"}, dump_data, mem_m[idx]);
            check({tag, ".last"}, dump_last, idx == DEPTH - 1);
            if (dump_last || idx == DEPTH - 1) done = 1;
            idx++;
         end
         pv = dump_valid; pr = dump_ready; pd = dump_data;
         step();
         cyc++;
      end
      dump_ready = 1'b0;
      check({tag, ".count"}, idx, DEPTH);
      if (done) begin
         mode_m = 0;
         wptr_m = 0;
      end
      check({tag, ".idle"}, dump_valid, 1'b0);
      chk_all({tag, ".post"});
   endtask

   task automatic rnd_addr(output logic [AW-1:0] a);
      if ($urandom_range(0, 9) == 0)
         a = AW'($urandom_range(DEPTH, 2**AW - 1));
      else
         a = AW'($urandom_range(0, DEPTH - 1));
   endtask

   initial begin
      logic [DW-1:0] pre [4];
      pre[0] = 8'h11; pre[1] = 8'h22;
      pre[2] = 8'h33; pre[3] = 8'h44;

      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.din0", din0, 0);
      check("rst.din1", din1, 0);
      check("rst.dv",   dump_valid, 0);
      check("rst.dl",   dump_last, 0);
      check("rst.dd",   dump_data, 0);
      check("rst.run",  run_active, 0);
      check("rst.err",  err_sticky, 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst.rdy", init_ready, 1);

      for (int i = 0; i < 4; i++) begin
         init_valid = 1'b1;
         init_data  = pre[i];
         init_last  = (i == 3);
         step();
         chk_all("pre4");
      end
      init_valid = 1'b0;
      init_last  = 1'b0;
      check("pre4.run_up", run_active, 1);

      ce0 = 1'b1; we0 = 1'b0; address0 = 5'd2;
      step(); chk_all("rd2");
      check("rd2.val", din0, 8'h33);
      ce0 = 1'b0;
      step(); step(); chk_all("hold");
      check("hold.val", din0, 8'h33);

      ce0 = 1'b1; address0 = 5'd1;
      ce1 = 1'b1; we1 = 1'b1; address1 = 5'd1; dout1 = 8'hAA;
      step(); chk_all("rfirst");
      check("rfirst.old", din0, 8'h22);
      ce1 = 1'b0; we1 = 1'b0;
      step(); chk_all("rfirst2");
      check("rfirst.new", din0, 8'hAA);

      ce0 = 1'b1; we0 = 1'b1; address0 = 5'd3; dout0 = 8'h55;
      ce1 = 1'b1; we1 = 1'b1; address1 = 5'd3; dout1 = 8'h66;
      step(); chk_all("ww");
      ce1 = 1'b0; we1 = 1'b0; we0 = 1'b0;
      step(); chk_all("ww_rd");
      check("ww.p1win", din0, 8'h66);

      address0 = AW'(DEPTH);
      step(); chk_all("oor");
      check("oor.din0", din0, 0);
      check("oor.err", err_sticky, 1);
      ce0 = 1'b0;

      for (int a = 0; a < DEPTH; a++) begin
         ce1 = 1'b1; we1 = 1'b1;
         address1 = AW'(a);
         dout1 = DW'($urandom);
         step(); chk_all("fill");
      end
      ce1 = 1'b0; we1 = 1'b0;

      for (int c = 0; c < 300; c++) begin
         ce0 = 1'($urandom_range(0, 1));
         we0 = ($urandom_range(0, 3) == 0);
         rnd_addr(address0);
         dout0 = DW'($urandom);
         ce1 = 1'($urandom_range(0, 1));
         we1 = ($urandom_range(0, 3) == 0);
         rnd_addr(address1);
         dout1 = DW'($urandom);
         step(); chk_all("rnd");
      end
      ce0 = 1'b0; we0 = 1'b0;
      ce1 = 1'b0; we1 = 1'b0;

      run_dump(1'b0, "dump1");

      for (int i = 0; i < 2 * DEPTH && mode_m == 0; i++) begin
         init_valid = 1'b1;
         init_data  = DW'($urandom);
         step(); chk_all("prefull");
      end
      check("prefull.run", run_active, 1);
      init_data = ~mem_m[0];
      step(); chk_all("init_in_run");
      init_valid = 1'b0;

      run_dump(1'b1, "dump2");

      for (int i = 0; i < 3; i++) begin
         init_valid = 1'b1;
         init_data  = DW'($urandom);
         init_last  = (i == 2);
         step(); chk_all("pre3");
      end
      init_valid = 1'b0;
      init_last  = 1'b0;
      dump_req = 1'b1;
      step();
      dump_req = 1'b0;
      dump_ready = 1'b0;
      for (int i = 0; i < 8 && !dump_valid; i++) step();
      check("mrst.valid", dump_valid, 1);
      #2 rst = 1'b0;
      #1;
      check("mrst.async_v", dump_valid, 0);
      check("mrst.run", run_active, 0);
      check("mrst.err", err_sticky, 0);
      mode_m = 0; wptr_m = 0; err_m = 1'b0;
      din0_m = '0; din1_m = '0;
      @(negedge clk) rst = 1'b1;
      step(); chk_all("mrst.post");
      check("mrst.dv", dump_valid, 0);

      ce0 = 1'b1; we0 = 1'b1; address0 = '0; dout0 = 8'h99;
      step(); chk_all("ce_init");
      ce0 = 1'b0; we0 = 1'b0;
      dump_req = 1'b1;
      step(); chk_all("dreq_init");
      check("dreq_init.dv", dump_valid, 0);
      dump_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
